data_stack: RTL

Parameterised LIFO holding the machine's data stack, with top-of-stack (TOS) and next-on-stack (NEXT) in dedicated registers and deeper entries in a spill array. It is the responder to the control unit's stack strobes (`data_pop`, `data_push`, `dw_tos`, `dw_next`) and returns `tos_or` for branch decisions. The datapath supplies the write data `tos_in` and `next_in`, selected by `d_select`. The same block, instantiated again, serves as the return stack.

---
 rtl/stack_pkg.sv | 24 ++
 rtl/data_stack_if.sv | 47 ++++
 rtl/stack_spill_ram.sv | 26 ++
 rtl/data_stack.sv | 134 +++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared types and defaults for the data and return stacks.
// Also provides the push/pop strobe decode used by the RTL and the bench.
package stack_pkg;

    localparam int STACK_WIDTH = 16;
    localparam int STACK_DEPTH = 16;

    typedef enum logic [1:0] {
        NONE    = 2'b00,
        POP     = 2'b01,
        PUSH    = 2'b10,
        ILLEGAL = 2'b11
    } stack_op_t;

    function automatic stack_op_t decode_op(input logic push, input logic pop);
        return stack_op_t'({push, pop});
    endfunction

    // Keeps the spill address at least one bit wide when DEPTH is 3.
    function automatic int spill_addr_width(input int entries);
        return (entries > 1) ? $clog2(entries) : 1;
    endfunction

endpackage

// File: rtl/data_stack_if.sv
// Stack strobe/data bundle between the control unit (master) and a stack (slave).
// The sticky error signals exist only when DATA_STACK_ERR_EN is defined.
interface data_stack_if
    import stack_pkg::*;
#(
    parameter int WIDTH = STACK_WIDTH,
    parameter int DEPTH = STACK_DEPTH
);
    localparam int DW = $clog2(DEPTH + 1);

    logic             push;
    logic             pop;
    logic             w_tos;
    logic             w_next;
    logic [WIDTH-1:0] tos_in;
    logic [WIDTH-1:0] next_in;
    logic [WIDTH-1:0] tos;
    logic [WIDTH-1:0] next;
    logic             tos_or;
    logic [DW-1:0]    depth;
    logic             empty;
    logic             full;
`ifdef DATA_STACK_ERR_EN
    logic             overflow;
    logic             underflow;
    logic             err_clr;
`endif

    modport master (
`ifdef DATA_STACK_ERR_EN
        output err_clr,
        input  overflow, underflow,
`endif
        output push, pop, w_tos, w_next, tos_in, next_in,
        input  tos, next, tos_or, depth, empty, full
    );

    modport slave (
`ifdef DATA_STACK_ERR_EN
        input  err_clr,
        output overflow, underflow,
`endif
        input  push, pop, w_tos, w_next, tos_in, next_in,
        output tos, next, tos_or, depth, empty, full
    );

endinterface

// File: rtl/stack_spill_ram.sv
// Register array backing the stack entries below TOS and NEXT.
// Synchronous write, asynchronous read, no reset.
module stack_spill_ram #(
    parameter int WIDTH   = 16,
    parameter int ENTRIES = 14,
    parameter int AW      = 4
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [ENTRIES];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_stack.sv
// LIFO with TOS/NEXT in registers and deeper entries in a spill array.
// Define DATA_STACK_ERR_EN to add sticky overflow/underflow flags and err_clr.
module data_stack
    import stack_pkg::*;
#(
    parameter int WIDTH = STACK_WIDTH,
    parameter int DEPTH = STACK_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    data_stack_if.slave bus
);

    localparam int DW    = $clog2(DEPTH + 1);
    localparam int SPILL = DEPTH - 2;
    localparam int AW    = spill_addr_width(SPILL);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

    logic [WIDTH-1:0] tos_q, tos_d;
    logic [WIDTH-1:0] next_q, next_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             spill_we;
    logic [AW-1:0]    spill_waddr;
    logic [AW-1:0]    spill_raddr;
    logic [WIDTH-1:0] spill_rdata;
    logic             set_ovf;
    logic             set_unf;
    stack_op_t        op;

    assign op = decode_op(bus.push, bus.pop);

    // spill_waddr is sp; the read side (sp-1) is only consulted when depth >= 3.
    assign spill_waddr = (depth_q >= DW'(2)) ? AW'(depth_q - DW'(2)) : '0;
    assign spill_raddr = AW'(depth_q - DW'(3));

    stack_spill_ram #(
        .WIDTH  (WIDTH),
        .ENTRIES(SPILL),
        .AW     (AW)
    ) u_spill (
        .clk    (clk),
        .we_i   (spill_we),
        .waddr_i(spill_waddr),
        .wdata_i(next_q),
        .raddr_i(spill_raddr),
        .rdata_o(spill_rdata)
    );

    always_comb begin
        tos_d    = tos_q;
        next_d   = next_q;
        depth_d  = depth_q;
        spill_we = 1'b0;
        set_ovf  = 1'b0;
        set_unf  = 1'b0;
        case (op)
            PUSH: begin
                if (depth_q == DEPTH_MAX) begin
                    set_ovf = 1'b1;
                end else begin
                    next_d   = tos_q;
                    spill_we = (depth_q >= DW'(2));
                    depth_d  = depth_q + DW'(1);
                    if (bus.w_tos) tos_d = bus.tos_in;
                end
            end
            POP: begin
                if (depth_q == '0) begin
                    set_unf = 1'b1;
                end else begin
                    depth_d = depth_q - DW'(1);
                    tos_d   = (depth_q == DW'(1)) ? '0 : next_q;
                    if (bus.w_tos) tos_d = bus.tos_in;
                    next_d  = (depth_q >= DW'(3)) ? spill_rdata : '0;
                end
            end
            ILLEGAL: begin
                if (bus.w_tos)  tos_d  = bus.tos_in;
                if (bus.w_next) next_d = bus.next_in;
                set_ovf = 1'b1;
                set_unf = 1'b1;
            end
            default: begin
                if (bus.w_tos)  tos_d  = bus.tos_in;
                if (bus.w_next) next_d = bus.next_in;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tos_q   <= '0;
            next_q  <= '0;
            depth_q <= '0;
        end else begin
            tos_q   <= tos_d;
            next_q  <= next_d;
            depth_q <= depth_d;
        end
    end

    assign bus.tos    = tos_q;
    assign bus.next   = next_q;
    assign bus.depth  = depth_q;
    assign bus.tos_or = |tos_q;
    assign bus.empty  = (depth_q == '0);
    assign bus.full   = (depth_q == DEPTH_MAX);

`ifdef DATA_STACK_ERR_EN
    logic ovf_q;
    logic unf_q;

    // A clear in the same cycle as a new error wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (bus.err_clr) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q | set_ovf;
            unf_q <= unf_q | set_unf;
        end
    end

    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
`else
    logic unused_flags;
    assign unused_flags = set_ovf | set_unf;
`endif

endmodule
